// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// register-bus addresses and the vector returned on a spurious acknowledge.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    localparam logic [1:0] ADDR_PEND   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_EOI    = 2'd3;

    localparam logic [7:0] SPURIOUS_VEC = 8'hFF;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder over up to 8 requests.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [2:0]   id,
    output logic         any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        id  = 3'd0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id  = 3'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller with pend/mask registers, a fixed
// lowest-index priority, vectored acknowledge and end-of-interrupt handshake.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NSRC     = 8,
    parameter logic [7:0]  VEC_BASE = 8'h20
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NSRC-1:0] src_i,
    input  logic            cs_i,
    input  logic            we_i,
    input  logic [1:0]      addr_i,
    input  logic [7:0]      wdata_i,
    output logic [7:0]      rdata_o,
    output logic            irq_o,
    input  logic            ack_i,
    output logic [7:0]      vec_o,
    output logic            vec_valid_o
);

    irq_state_t      state_q, state_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] src_q;
    logic            armed_q;
    logic [2:0]      isr_id_q;
    logic [7:0]      vec_q;
    logic            vec_valid_q;

    logic            wr_en;
    logic [NSRC-1:0] pend_wclr;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] edge_set;
    logic [NSRC-1:0] eligible;
    logic [2:0]      win_id;
    logic            win_any;
    logic            take;
    logic            spurious;

    assign wr_en     = cs_i & we_i;
    assign pend_wclr = (wr_en && addr_i == ADDR_PEND) ? wdata_i[NSRC-1:0] : '0;
    // The first clock after reset only loads the history, so a line already
    // high at release is never mistaken for a fresh edge.
    assign edge_set  = src_i & ~src_q & {NSRC{armed_q}};
    // A PEND clear in the acknowledge cycle already removes those sources
    // from the arbitration.
    assign eligible  = pend_q & ~pend_wclr & mask_q;

    irq_prio_enc #(.N(NSRC)) u_prio (
        .req (eligible),
        .id  (win_id),
        .any (win_any)
    );

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        spurious = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|(pend_q & mask_q)) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_i) begin
                    if (win_any) begin
                        take    = 1'b1;
                        state_d = ST_SERVICE;
                    end else begin
                        spurious = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else if (!(|(pend_q & mask_q))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_en && addr_i == ADDR_EOI) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            ack_clr[i] = take && (win_id == 3'(i));
        end
        pend_d = (pend_q & ~pend_wclr & ~ack_clr) | edge_set;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            mask_q      <= '0;
            src_q       <= '0;
            armed_q     <= 1'b0;
            isr_id_q    <= 3'd0;
            vec_q       <= 8'h00;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            src_q       <= src_i;
            armed_q     <= 1'b1;
            vec_valid_q <= take | spurious;
            if (wr_en && addr_i == ADDR_MASK) mask_q <= wdata_i[NSRC-1:0];
            if (take) begin
                isr_id_q <= win_id;
                vec_q    <= VEC_BASE + {5'd0, win_id};
            end else if (spurious) begin
                vec_q <= SPURIOUS_VEC;
            end
        end
    end

    always_comb begin
        rdata_o = 8'h00;
        if (cs_i) begin
            case (addr_i)
                ADDR_PEND:   rdata_o[NSRC-1:0] = pend_q;
                ADDR_MASK:   rdata_o[NSRC-1:0] = mask_q;
                ADDR_STATUS: rdata_o = {state_q == ST_SERVICE, 4'b0000, isr_id_q};
                default:     rdata_o = 8'h00;
            endcase
        end
    end

    assign irq_o       = (state_q == ST_REQ);
    assign vec_o       = vec_q;
    assign vec_valid_o = vec_valid_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: per-scenario tasks plus a vector scoreboard.
module tb_irq_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] src_i = 8'h00;
    logic       cs_i = 1'b0;
    logic       we_i = 1'b0;
    logic [1:0] addr_i = 2'd0;
    logic [7:0] wdata_i = 8'h00;
    logic [7:0] rdata_o;
    logic       irq_o;
    logic       ack_i = 1'b0;
    logic [7:0] vec_o;
    logic       vec_valid_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    irq_ctrl #(.NSRC(8), .VEC_BASE(8'h20)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .src_i       (src_i),
        .cs_i        (cs_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .irq_o       (irq_o),
        .ack_i       (ack_i),
        .vec_o       (vec_o),
        .vec_valid_o (vec_valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Every vector pulse must match the oldest expected acknowledge result.
    always @(negedge clk_i) begin
        if (vec_valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL vec_unexpected got vec_o=%02h, required no pulse", vec_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (vec_o !== e) begin
                    errors++;
                    $display("[TB] FAIL vec_value got %02h, required %02h", vec_o, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        cs_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        tick();
        cs_i = 1'b0; we_i = 1'b0; wdata_i = 8'h00;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        cs_i = 1'b1; we_i = 1'b0; addr_i = a;
        #1;
        d = rdata_o;
        cs_i = 1'b0;
    endtask

    task automatic do_ack(input logic [7:0] expv);
        exp_q.push_back(expv);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
    endtask

    task automatic pulse_src(input logic [7:0] s);
        src_i = s;
        tick();
        src_i = 8'h00;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        apply_reset();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b, required 0", irq_o); end
        checks++; if (vec_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_vvalid got %b, required 0", vec_valid_o); end
        checks++; if (vec_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_vec got %02h, required 00", vec_o); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_pend got %02h, required 00", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_mask got %02h, required 00", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_status got %02h, required 00", d); end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        bus_write(2'd1, 8'h01);
        bus_read(2'd1, d);
        checks++; if (d !== 8'h01) begin errors++; $display("[TB] FAIL basic_mask got %02h, required 01", d); end
        pulse_src(8'h01);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency1 got %b, required 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency2 got %b, required 1", irq_o); end
        do_ack(8'h20);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_irq_svc got %b, required 0", irq_o); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL basic_pend got %02h, required 00", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 8'h80) begin errors++; $display("[TB] FAIL basic_status got %02h, required 80", d); end
        bus_write(2'd3, 8'h00);
        bus_read(2'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL basic_eoi_status got %02h, required 00", d); end
    endtask

    task automatic test_priority();
        logic [7:0] d;
        bus_write(2'd1, 8'hFF);
        pulse_src(8'h24);
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL prio_irq got %b, required 1", irq_o); end
        do_ack(8'h22);
        bus_read(2'd2, d);
        checks++; if (d !== 8'h82) begin errors++; $display("[TB] FAIL prio_status got %02h, required 82", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h20) begin errors++; $display("[TB] FAIL prio_pend got %02h, required 20", d); end
        bus_write(2'd3, 8'h00);
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL prio_rereq got %b, required 1", irq_o); end
        do_ack(8'h25);
        bus_write(2'd3, 8'h00);
        bus_read(2'd2, d);
        checks++; if (d !== 8'h05) begin errors++; $display("[TB] FAIL prio_status2 got %02h, required 05", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL prio_pend2 got %02h, required 00", d); end
    endtask

    task automatic test_masked();
        logic [7:0] d;
        bus_write(2'd1, 8'h00);
        pulse_src(8'h08);
        tick();
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL mask_irq got %b, required 0", irq_o); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h08) begin errors++; $display("[TB] FAIL mask_pend got %02h, required 08", d); end
        bus_write(2'd1, 8'h08);
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL mask_unmask got %b, required 1", irq_o); end
        bus_write(2'd0, 8'h08);
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL mask_withdraw got %b, required 0", irq_o); end
    endtask

    task automatic test_spurious();
        logic [7:0] d;
        bus_write(2'd1, 8'hFF);
        pulse_src(8'h40);
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL spur_irq got %b, required 1", irq_o); end
        exp_q.push_back(8'hFF);
        cs_i = 1'b1; we_i = 1'b1; addr_i = 2'd0; wdata_i = 8'hFF; ack_i = 1'b1;
        tick();
        cs_i = 1'b0; we_i = 1'b0; wdata_i = 8'h00; ack_i = 1'b0;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL spur_irq_after got %b, required 0", irq_o); end
        bus_read(2'd2, d);
        checks++; if (d !== 8'h05) begin errors++; $display("[TB] FAIL spur_status got %02h, required 05", d); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL spur_pend got %02h, required 00", d); end
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL spur_idle got %b, required 0", irq_o); end
    endtask

    task automatic test_service_nest();
        logic [7:0] d;
        pulse_src(8'h01);
        tick();
        do_ack(8'h20);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        pulse_src(8'h02);
        tick();
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL nest_irq got %b, required 0", irq_o); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h02) begin errors++; $display("[TB] FAIL nest_pend got %02h, required 02", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 8'h80) begin errors++; $display("[TB] FAIL nest_status got %02h, required 80", d); end
        bus_write(2'd3, 8'h00);
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL nest_after_eoi got %b, required 1", irq_o); end
        do_ack(8'h21);
        tick();
        bus_read(2'd2, d);
        checks++; if (d !== 8'h81) begin errors++; $display("[TB] FAIL nest_status2 got %02h, required 81", d); end
        rst_i = 1'b1;
        #1;
        checks++; if ({irq_o, vec_valid_o, vec_o} !== 10'h000) begin errors++; $display("[TB] FAIL rst_svc_outputs got irq=%b vv=%b vec=%02h, required all 0", irq_o, vec_valid_o, vec_o); end
        bus_read(2'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL rst_svc_status got %02h, required 00", d); end
        tick();
        rst_i = 1'b0;
        bus_read(2'd1, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL rst_svc_mask got %02h, required 00", d); end
        tick();
        tick();
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_svc_irq got %b, required 0", irq_o); end
    endtask

    task automatic test_ack_idle();
        logic [7:0] d;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        tick();
        bus_read(2'd2, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL ackidle_status got %02h, required 00", d); end
    endtask

    task automatic test_src_through_reset();
        logic [7:0] d;
        rst_i = 1'b1;
        src_i = 8'h01;
        tick();
        rst_i = 1'b0;
        bus_write(2'd1, 8'h01);
        tick();
        tick();
        bus_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL held_pend got %02h, required 00", d); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL held_irq got %b, required 0", irq_o); end
        src_i = 8'h00;
        tick();
        src_i = 8'h01;
        tick();
        bus_read(2'd0, d);
        checks++; if (d !== 8'h01) begin errors++; $display("[TB] FAIL held_newedge got %02h, required 01", d); end
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL held_irq2 got %b, required 1", irq_o); end
        src_i = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_masked();
        test_spurious();
        test_service_nest();
        test_ack_idle();
        test_src_through_reset();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL vec_missing got %0d outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 8, number of interrupt sources (1..8).
REQ-002 Parameter VEC_BASE, default 8'h20, vector number issued for source 0.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 src_i  input  NSRC  interrupt lines, synchronous to clk_i, rising-edge triggered.
REQ-006 cs_i  input  1  register-bus select.
REQ-007 we_i  input  1  write strobe, qualified by cs_i.
REQ-008 addr_i  input  2  register select: 0 PEND, 1 MASK, 2 STATUS, 3 EOI.
REQ-009 wdata_i  input  8  write data.
REQ-010 rdata_o  output  8  read data, combinational from addr_i while cs_i=1, else 8'h00.
REQ-011 irq_o  output  1  interrupt request to the CPU irq_i input.
REQ-012 ack_i  input  1  CPU interrupt-acknowledge, one-cycle pulse.
REQ-013 vec_o  output  8  vector number, valid only while vec_valid_o=1.
REQ-014 vec_valid_o  output  1  one-cycle pulse, the cycle after ack_i is sampled.

Function
REQ-015 Rising edge on src_i[n] (0 last cycle, 1 now) SHALL set pend[n] on the next clock edge.
REQ-016 Write to PEND SHALL clear each pend bit whose wdata_i bit is 1 (write-1-to-clear); a same-cycle edge set SHALL win over clear.
REQ-017 MASK SHALL be read/write; bit=1 enables the source; masked sources still latch pend.
REQ-018 Priority: lowest index among (pend & mask) wins.
REQ-019 FSM states IDLE, REQ, SERVICE.
REQ-020 IDLE -> REQ when (pend & mask) != 0; irq_o=1 exactly while in REQ.
REQ-021 REQ -> IDLE when (pend & mask) becomes 0 without ack_i.
REQ-022 REQ with ack_i=1: latch winner id into isr_id, clear pend[id], next cycle vec_valid_o=1 and vec_o=VEC_BASE+id, -> SERVICE.
REQ-023 ack_i in REQ with (pend & mask)=0 in that cycle: vec_o=8'hFF (spurious), vec_valid_o=1, -> IDLE, no pend change.
REQ-024 ack_i outside REQ SHALL be ignored.
REQ-025 SERVICE: irq_o=0 (no nesting); new edges still latch pend.
REQ-026 Any write to EOI in SERVICE -> IDLE next cycle; EOI write in other states ignored.
REQ-027 STATUS read: bit7 = (state==SERVICE), bits2:0 = isr_id, bits6:3 = 0.
REQ-028 PEND and MASK reads return bits NSRC-1:0, upper bits 0.
REQ-029 Latency: src_i edge to irq_o high = 2 cycles from IDLE with source unmasked.

Reset
REQ-030 On rst_i: state=IDLE, pend=0, mask=0, isr_id=0, edge-detect history=0, irq_o=0, vec_valid_o=0, vec_o=0.
REQ-031 Reset mid-REQ or mid-SERVICE SHALL abandon the request; no vec_valid_o pulse after reset release until a new ack.
REQ-032 A src_i held high through reset release SHALL NOT set pend (history cleared to 0 counts only a post-release rising edge; history samples src_i from first clock after release).

Structure
REQ-033 Package irq_pkg: state enum, register address constants (PEND/MASK/STATUS/EOI), SPURIOUS_VEC=8'hFF.
REQ-034 One sub-module irq_prio_enc: combinational NSRC-bit lowest-index-first encoder, outputs id and any flag.
REQ-035 irq_ctrl instantiated in top beside the memory and CPU; irq_o drives the CPU irq_i.

Verification
REQ-036 MASK=8'h01, pulse src_i[0] -> irq_o high 2 cycles later; ack -> vec_o=8'h20 pulse, PEND reads 0, STATUS=8'h80.
REQ-037 MASK=8'hFF, edges on src 5 and 2 same cycle, ack -> vec_o=8'h22; EOI -> re-request, ack -> vec_o=8'h25.
REQ-038 MASK=0, edge src 3 -> PEND=8'h08, irq_o stays 0; write MASK=8'h08 -> irq_o rises.
REQ-039 In REQ, write PEND=8'hFF and ack same cycle -> vec_o=8'hFF, state IDLE, irq_o 0.
REQ-040 In SERVICE, edge src 1 -> irq_o stays 0 until EOI, then rises; rst_i during SERVICE -> all outputs 0, STATUS=0.
